// File: rtl/blk_sched_if.sv
// blk_sched_if: video timing inputs and buffer strobes of the block sequencer.
// The testbench/source drives through the master modport; blk_sched uses slave.
interface blk_sched_if;
   logic de_i;
   logic vs_i;
   logic de_o;
   logic h_save_o;
   logic v_save_o;
   logic frame_o;
   logic err_o;

   modport master (
      output de_i,
      output vs_i,
      input  de_o,
      input  h_save_o,
      input  v_save_o,
      input  frame_o,
      input  err_o
   );

   modport slave (
      input  de_i,
      input  vs_i,
      output de_o,
      output h_save_o,
      output v_save_o,
      output frame_o,
      output err_o
   );
endinterface

// File: rtl/blk_sched.sv
// blk_sched: sequencer for the block-luminance buffer.
// Tracks pixel/block position inside the active window from raw de/vsync and
// issues registered h_save (per block), v_save (per block row / frame start)
// and frame strobes, all aligned to the 1-cycle-delayed de.
// Optional geometry checker driving err_o: define BLK_SCHED_CHECK_EN.
module blk_sched #(
   parameter int HBLKS = 10,
   parameter int VBLKS = 10,
   parameter int BW    = 30,
   parameter int BH    = 30
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   blk_sched_if.slave bus
);
   localparam int PXW = (BW    > 1) ? $clog2(BW)    : 1;
   localparam int BXW = (HBLKS > 1) ? $clog2(HBLKS) : 1;
   localparam int LNW = (BH    > 1) ? $clog2(BH)    : 1;
   localparam int BYW = (VBLKS > 1) ? $clog2(VBLKS) : 1;

   localparam logic [PXW-1:0] PX_LAST = PXW'(BW - 1);
   localparam logic [BXW-1:0] BX_LAST = BXW'(HBLKS - 1);
   localparam logic [LNW-1:0] LN_LAST = LNW'(BH - 1);
   localparam logic [BYW-1:0] BY_LAST = BYW'(VBLKS - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, LINE_END, DONE} state_t;

   state_t         state_reg, state_next;
   logic [PXW-1:0] px_reg, px_next;
   logic [BXW-1:0] bx_reg, bx_next;
   logic [LNW-1:0] ln_reg, ln_next;
   logic [BYW-1:0] by_reg, by_next;
   // Set once the last block of the line has been saved; later pixels are excess.
   logic           line_full_reg, line_full_next;
   logic           de_reg, vs_reg;
   logic           h_save_reg, h_save_next;
   logic           v_save_reg, v_save_next;
   logic           frame_reg, frame_next;

   logic           vs_rise, de_fall;
   logic           count_pixel, line_end;

   assign vs_rise = bus.vs_i & ~vs_reg;
   assign de_fall = ~bus.de_i & de_reg;

   // State, counters, edge-detect copies and output strobes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         px_reg        <= '0;
         bx_reg        <= '0;
         ln_reg        <= '0;
         by_reg        <= '0;
         line_full_reg <= 1'b0;
         de_reg        <= 1'b0;
         vs_reg        <= 1'b0;
         h_save_reg    <= 1'b0;
         v_save_reg    <= 1'b0;
         frame_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         px_reg        <= px_next;
         bx_reg        <= bx_next;
         ln_reg        <= ln_next;
         by_reg        <= by_next;
         line_full_reg <= line_full_next;
         de_reg        <= bus.de_i;
         vs_reg        <= bus.vs_i;
         h_save_reg    <= h_save_next;
         v_save_reg    <= v_save_next;
         frame_reg     <= frame_next;
      end
   end

   // Next state, counter updates and strobe decisions; vsync restart overrides all
   always_comb begin
      state_next     = state_reg;
      px_next        = px_reg;
      bx_next        = bx_reg;
      ln_next        = ln_reg;
      by_next        = by_reg;
      line_full_next = line_full_reg;
      h_save_next    = 1'b0;
      v_save_next    = 1'b0;
      frame_next     = 1'b0;
      count_pixel    = 1'b0;
      line_end       = 1'b0;

      if (vs_rise) begin
         state_next     = ACTIVE;
         px_next        = '0;
         bx_next        = '0;
         ln_next        = '0;
         by_next        = '0;
         line_full_next = 1'b0;
         v_save_next    = 1'b1;
      end else begin
         case (state_reg)
            ACTIVE: begin
               count_pixel = bus.de_i;
               line_end    = de_fall;
            end
            LINE_END: begin
               // frame_reg is high here only right after the last block row
               if (frame_reg) begin
                  state_next = DONE;
               end else begin
                  state_next  = ACTIVE;
                  count_pixel = bus.de_i;
               end
            end
            default: ;
         endcase

         if (count_pixel) begin
            if (px_reg == PX_LAST) begin
               px_next = '0;
               if (!line_full_reg) begin
                  h_save_next = 1'b1;
                  if (bx_reg == BX_LAST) begin
                     line_full_next = 1'b1;
                  end else begin
                     bx_next = bx_reg + BXW'(1);
                  end
               end
            end else begin
               px_next = px_reg + PXW'(1);
            end
         end

         if (line_end) begin
            state_next     = LINE_END;
            px_next        = '0;
            bx_next        = '0;
            line_full_next = 1'b0;
            if (ln_reg == LN_LAST) begin
               ln_next     = '0;
               v_save_next = 1'b1;
               if (by_reg == BY_LAST) begin
                  by_next    = '0;
                  frame_next = 1'b1;
               end else begin
                  by_next = by_reg + BYW'(1);
               end
            end else begin
               ln_next = ln_reg + LNW'(1);
            end
         end
      end
   end

   assign bus.de_o     = de_reg;
   assign bus.h_save_o = h_save_reg;
   assign bus.v_save_o = v_save_reg;
   assign bus.frame_o  = frame_reg;

`ifdef BLK_SCHED_CHECK_EN
   logic err_reg, err_next;
   logic extra_reg, extra_next;
   logic bad_start, line_bad;

   // A line starting while the frame is finished (DONE, or about to enter it)
   assign bad_start = bus.de_i & ~de_reg &
                      ((state_reg == DONE) || ((state_reg == LINE_END) && frame_reg));
   // Exact line length means the last block was saved and nothing followed it
   assign line_bad  = ~line_full_reg | extra_reg;

   // Sticky error and excess-pixel tracking; vsync re-evaluates and clears
   always_comb begin
      err_next   = err_reg;
      extra_next = extra_reg;
      if (vs_rise) begin
         err_next   = (state_reg != DONE) && ((ln_reg != '0) || (by_reg != '0));
         extra_next = 1'b0;
      end else begin
         if (bad_start || (line_end && line_bad)) begin
            err_next = 1'b1;
         end
         if (line_end) begin
            extra_next = 1'b0;
         end else if (count_pixel && line_full_reg) begin
            extra_next = 1'b1;
         end
      end
   end

   // Checker registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_reg   <= 1'b0;
         extra_reg <= 1'b0;
      end else begin
         err_reg   <= err_next;
         extra_reg <= extra_next;
      end
   end

   assign bus.err_o = err_reg;
`else
   assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blk_sched.sv
// tb_blk_sched: directed + randomized stimulus for blk_sched, checked every
// cycle against a pixel-index / line-index reference model.
`timescale 1ns/1ps
module tb_blk_sched;
   localparam int HBLKS       = 2;
   localparam int VBLKS       = 2;
   localparam int BW          = 4;
   localparam int BH          = 2;
   localparam int LINE_PIX    = HBLKS * BW;
   localparam int FRAME_LINES = VBLKS * BH;
`ifdef BLK_SCHED_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   blk_sched_if bus();

   blk_sched #(
      .HBLKS (HBLKS),
      .VBLKS (VBLKS),
      .BW    (BW),
      .BH    (BH)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: 0 = waiting for vsync, 1 = in frame, 2 = frame finished
   int m_mode;
   bit m_prev_de, m_prev_vs;
   int m_pix;   // de pixels seen in the current line
   int m_line;  // completed lines in the current frame
   bit m_err;
   bit e_de, e_h, e_v, e_f;

   int seen_h, seen_v, seen_f;

   task automatic model_reset();
      m_mode = 0; m_prev_de = 1'b0; m_prev_vs = 1'b0;
      m_pix = 0; m_line = 0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic de, input logic vs);
      bit rise  = vs && !m_prev_vs;
      bit fall  = !de && m_prev_de;
      bit drise = de && !m_prev_de;
      e_de = de; e_h = 1'b0; e_v = 1'b0; e_f = 1'b0;
      if (rise) begin
         if (CHK) m_err = (m_mode != 2) && (m_line != 0);
         m_mode = 1; m_pix = 0; m_line = 0; e_v = 1'b1;
      end else if (m_mode == 1) begin
         if (de) begin
            if (m_pix < LINE_PIX && (m_pix % BW) == BW - 1) e_h = 1'b1;
            m_pix++;
         end else if (fall) begin
            if (CHK && m_pix != LINE_PIX) m_err = 1'b1;
            if ((m_line % BH) == BH - 1) e_v = 1'b1;
            if (m_line == FRAME_LINES - 1) begin
               e_f = 1'b1; m_mode = 2; m_line = 0;
            end else begin
               m_line++;
            end
            m_pix = 0;
         end
      end else if (m_mode == 2) begin
         if (CHK && drise) m_err = 1'b1;
      end
      m_prev_de = de; m_prev_vs = vs;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance model, compare all outputs after the edge
   task automatic step(input logic de, input logic vs);
      bus.de_i = de;
      bus.vs_i = vs;
      model_step(de, vs);
      @(posedge clk); #1;
      chk("de_o",   bus.de_o,     e_de);
      chk("h_save", bus.h_save_o, e_h);
      chk("v_save", bus.v_save_o, e_v);
      chk("frame",  bus.frame_o,  e_f);
      chk("err",    bus.err_o,    m_err);
      if (bus.h_save_o) seen_h++;
      if (bus.v_save_o) seen_v++;
      if (bus.frame_o)  seen_f++;
   endtask

   task automatic line_tx(input int pixels, input int blank);
      int h0 = seen_h, v0 = seen_v, f0 = seen_f;
      for (int i = 0; i < pixels; i++) step(1'b1, 1'b0);
      for (int i = 0; i < blank; i++)  step(1'b0, 1'b0);
      $display("[TB] line pixels=%0d blank=%0d h_save=%0d v_save=%0d frame=%0d err=%b",
               pixels, blank, seen_h - h0, seen_v - v0, seen_f - f0, bus.err_o);
   endtask

   task automatic vsync();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      $display("[TB] vsync v_save=%0d err=%b", seen_v, bus.err_o);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_de_o"},   bus.de_o,     1'b0);
      chk({tag, "_h_save"}, bus.h_save_o, 1'b0);
      chk({tag, "_v_save"}, bus.v_save_o, 1'b0);
      chk({tag, "_frame"},  bus.frame_o,  1'b0);
      chk({tag, "_err"},    bus.err_o,    1'b0);
   endtask

   initial begin
      int len;
      int nl;
      seen_h = 0; seen_v = 0; seen_f = 0;
      bus.de_i = 1'b0;
      bus.vs_i = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset_check("reset");
      #3 rst_n = 1'b1;

      // de activity before the first vsync: no strobes
      repeat (3) line_tx($urandom_range(5, 9), $urandom_range(1, 3));

      // Nominal frame of 4 lines x 8 pixels
      vsync();
      for (int i = 0; i < FRAME_LINES; i++) line_tx(LINE_PIX, $urandom_range(1, 4));

      // Extra line after the frame completed
      line_tx(LINE_PIX, 2);

      // Overlong line
      vsync();
      line_tx(LINE_PIX + 1, 2);
      line_tx(LINE_PIX, 2);

      // vsync mid-frame after one line
      vsync();
      line_tx(LINE_PIX, 2);
      vsync();

      // vsync rising together with the de falling edge: restart wins
      line_tx(LINE_PIX, 0);
      vsync();
      for (int i = 0; i < FRAME_LINES; i++) line_tx(LINE_PIX, 1);

      // Reset asserted mid-line, outputs drop without a clock edge
      vsync();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      reset_check("async_rst");
      model_reset();
      bus.de_i = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      line_tx(LINE_PIX, 2);
      line_tx(LINE_PIX, 2);
      vsync();
      for (int i = 0; i < FRAME_LINES; i++) line_tx(LINE_PIX, $urandom_range(1, 3));

      // Randomized frames: random line count, lengths and blanking
      repeat (10) begin
         vsync();
         nl = $urandom_range(1, FRAME_LINES + 1);
         for (int i = 0; i < nl; i++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(LINE_PIX - 2, LINE_PIX + 2)
                                              : LINE_PIX;
            line_tx(len, $urandom_range(1, 4));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/blk_sched.md
# blk_sched

Sequencer for the block-luminance buffer. It tracks pixel and line position inside the active video window from raw sync/enable inputs and issues the per-block `h_save` strobes and per-block-row `v_save` strobes the buffer consumes. It sits between the video timing input and the buffer, with all outputs registered and aligned to a 1-cycle-delayed `de`.

## Interface
- `HBLKS`, default 10: horizontal blocks per frame.
- `VBLKS`, default 10: vertical blocks per frame.
- `BW`, default 30: block width in pixels.
- `BH`, default 30: block height in lines.

Ports:
- `clk_i` in 1: pixel clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `de_i` in 1: data enable, high on active pixels.
- `vs_i` in 1: vsync, active high; a rising edge marks frame start.
- `de_o` out 1: `de_i` delayed by 1 cycle.
- `h_save_o` out 1: pulse on the last pixel of each horizontal block, aligned with `de_o`.
- `v_save_o` out 1: pulse that clears the accumulators at frame start and after each completed block row.
- `frame_o` out 1: pulse when the last block row of a frame completes.
- `err_o` out 1: sticky geometry error (see Configuration).

## Operation
- Counters:
  - `px`: 0..BW-1, pixel within block.
  - `bx`: 0..HBLKS-1, block column.
  - `ln`: 0..BH-1, line within block.
  - `by`: 0..VBLKS-1, block row.
- Widths: `$clog2` of each range, minimum 1 bit.
- States:
  - `IDLE`: after reset. Ignores `de_i` until the first `vs_i` rising edge, then goes to `ACTIVE`.
  - `ACTIVE`: on each `de_i` cycle, increment `px`. At `px==BW-1`, wrap `px` to 0, assert `h_save_o` and increment `bx`.
  - `LINE_END`: entered on the `de_i` falling edge. Reset `px`/`bx` and advance `ln`. If `ln` was BH-1: assert `v_save_o`, wrap `ln` and advance `by`. If `by` was VBLKS-1: assert `frame_o` and go to `DONE`. Otherwise return to `ACTIVE`.
  - `DONE`: ignores `de_i` until the next `vs_i` rising edge.
- Any `vs_i` rising edge, in any state:
  - zero all counters;
  - pulse `v_save_o`;
  - go to `ACTIVE`.
- `de_i` pixels beyond HBLKS·BW in a line: no `h_save_o`; `bx` saturates at HBLKS-1.
- `h_save_o` and `v_save_o` are never asserted in the same cycle. `v_save_o` only occurs while `de_o` is low.

## Timing
- Reset values: all outputs 0, all counters 0, state `IDLE`.
- Latency: `de_o`, `h_save_o`, `v_save_o` and `frame_o` are registered, 1 cycle after the causing input edge or pixel.
- `h_save_o` is high exactly in the `de_o` cycle of pixel index k·BW-1, for k = 1..HBLKS.
- `v_save_o`:
  - block-row end: 1 cycle after the `de_i` falling edge of line n·BH-1;
  - frame start: 1 cycle after a `vs_i` rising edge.
- `frame_o` coincides with the final-row `v_save_o`.
- `vs_i` rising in the same cycle as a `de_i` falling edge: frame restart wins, and `ln`/`by` do not advance.
- `rst_ni` low mid-line: outputs drop to 0 asynchronously. After release, the block waits in `IDLE` for the next vsync.
- Edge detection uses registered copies of `de_i`/`vs_i`. There is no other pipeline.

## Configuration
- `BLK_SCHED_CHECK_EN` defined: `err_o` sets and stays high until the next `vs_i` rising edge or reset when any of these occurs:
  - a line's `de_i` count differs from HBLKS·BW;
  - a line starts in `DONE`;
  - a `vs_i` rising edge arrives while `by`/`ln` ≠ 0/0 and the state is not `DONE`.
- Not defined: `err_o` is tied to 0 and the check logic is omitted.

## Test plan
1. HBLKS=2, VBLKS=2, BW=4, BH=2; vsync, then 4 lines of 8 `de` pixels -> `h_save_o` at `de_o` pixels 3 and 7 of every line; `v_save_o` after lines 1 and 3 plus once at vsync; `frame_o` with the last one; `err_o`=0.
2. Same config, a line of 9 pixels -> only 2 `h_save_o` pulses in that line; with `BLK_SCHED_CHECK_EN`, `err_o`=1 until the next vsync.
3. `de_i` pulses before the first vsync -> no strobes, state stays `IDLE`.
4. vsync mid-frame after 1 line -> `v_save_o` pulse 1 cycle later, counters restart; checker build sets `err_o`.
5. `rst_ni` asserted mid-line -> all outputs 0 immediately; no strobes until vsync after release.
6. 5th line after a completed frame (`DONE`) -> no `h_save_o`; checker build sets `err_o`.
